// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: datapath constants, the
// alucontrol op codes (also used by the ALU decoder) and the FSM states.
package alu_pkg;

    localparam int XLEN    = 19;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_MUL     = 4'b0010,
        ALU_DIV     = 4'b0011,
        ALU_INC     = 4'b0100,
        ALU_DEC     = 4'b0101,
        ALU_AND     = 4'b0110,
        ALU_OR      = 4'b0111,
        ALU_XOR     = 4'b1000,
        ALU_NOT     = 4'b1001,
        ALU_REM     = 4'b1010,
        ALU_SLT     = 4'b1011,
        ALU_SLL     = 4'b1100,
        ALU_SRL     = 4'b1101,
        ALU_SRA     = 4'b1110,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } alu_state_e;

    // DIV and REM share the iterative divider.
    function automatic logic is_div_op(alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The quotient and
// remainder outputs are the values produced by the step taken at the current
// edge, so the owner can register them on the same edge that done is high.
// A zero divisor needs no special case: every trial subtraction succeeds, so
// the quotient fills with ones and the remainder ends up equal to the dividend.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             running_q;
    logic             dbz_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // One restoring step: shift the next dividend bit in and try the subtraction.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - dvs_q;
        ge      = (shifted >= {1'b0, dvs_q});
    end

    assign remainder = ge ? diff : shifted[WIDTH-1:0];
    assign quotient  = {quo_q[WIDTH-2:0], ge};
    assign done      = running_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign dbz       = dbz_q;

    // Load operands on start, then advance one bit per edge until the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (start) begin
            rem_q     <= '0;
            quo_q     <= dividend;
            dvs_q     <= divisor;
            cnt_q     <= '0;
            running_q <= 1'b1;
            dbz_q     <= (divisor == '0);
        end else if (running_q) begin
            rem_q <= remainder;
            quo_q <= quotient;
            if (done) begin
                running_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Execution-stage ALU. Logic, shift and add ops finish in one cycle; MUL, DIV
// and REM iterate for WIDTH edges while in_ready is low so control can stall.
// Optional macro ALU_FAST_MUL_EN: when defined, MUL is computed combinationally
// and handled as a single-cycle op; DIV/REM always use the iterative divider.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    alu_state_e         state_q;
    alu_state_e         state_d;
    alu_op_e            op_in;
    alu_op_e            op_q;
    logic               accept;
    logic               iter_op;
    logic               div_start;
    logic               finish;
    logic [CNT_W-1:0]   iter_cnt_q;
    logic [WIDTH-1:0]   mul_acc_q;
    logic [WIDTH-1:0]   mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;
    logic [WIDTH-1:0]   mul_acc_next;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH-1:0]   iter_res;
    logic [SHAMT_W-1:0] shamt;
    logic               shamt_ovf;
    logic signed [WIDTH-1:0] sra_res;
    logic               div_done;
    logic [WIDTH-1:0]   div_quotient;
    logic [WIDTH-1:0]   div_remainder;
    logic               div_dbz;

    assign op_in     = alu_op_e'(alucontrol);
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == ITER);
    assign accept    = in_valid && in_ready;
    assign div_start = accept && is_div_op(op_in);

`ifdef ALU_FAST_MUL_EN
    assign iter_op = is_div_op(op_in);
`else
    assign iter_op = is_div_op(op_in) || (op_in == ALU_MUL);
`endif

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (srca),
        .divisor  (srcb),
        .done     (div_done),
        .quotient (div_quotient),
        .remainder(div_remainder),
        .dbz      (div_dbz)
    );

    // Single-cycle result for the op being offered this cycle.
    always_comb begin
        shamt      = srcb[SHAMT_W-1:0];
        shamt_ovf  = (int'(shamt) >= WIDTH);
        sra_res    = $signed(srca) >>> shamt;
        single_res = '0;
        case (op_in)
            ALU_ADD: single_res = srca + srcb;
            ALU_SUB: single_res = srca - srcb;
            ALU_INC: single_res = srca + WIDTH'(1);
            ALU_DEC: single_res = srca - WIDTH'(1);
            ALU_AND: single_res = srca & srcb;
            ALU_OR:  single_res = srca | srcb;
            ALU_XOR: single_res = srca ^ srcb;
            ALU_NOT: single_res = ~srca;
            ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            ALU_SLL: single_res = shamt_ovf ? '0 : (srca << shamt);
            ALU_SRL: single_res = shamt_ovf ? '0 : (srca >> shamt);
            ALU_SRA: begin
                if (shamt_ovf) begin
                    single_res = {WIDTH{srca[WIDTH-1]}};
                end else begin
                    single_res = sra_res;
                end
            end
`ifdef ALU_FAST_MUL_EN
            ALU_MUL: single_res = srca * srcb;
`endif
            default: single_res = '0;
        endcase
    end

    // Final-step result of the iterative op currently in flight.
    always_comb begin
        mul_acc_next = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
        finish       = 1'b0;
        iter_res     = mul_acc_next;
        if (state_q == ITER) begin
            finish = is_div_op(op_q) ? div_done : (iter_cnt_q == CNT_W'(WIDTH - 1));
        end
        case (op_q)
            ALU_DIV: iter_res = div_quotient;
            ALU_REM: iter_res = div_remainder;
            default: iter_res = mul_acc_next;
        endcase
    end

    // State register; reset also aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter ITER on accepting an iterative op, leave on its last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && iter_op) state_d = ITER;
            ITER: if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture operands, step the shift-add multiplier and register results and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            op_q        <= ALU_ADD;
            iter_cnt_q  <= '0;
            mul_acc_q   <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                op_q       <= op_in;
                iter_cnt_q <= '0;
                mul_acc_q  <= '0;
                mul_a_q    <= srca;
                mul_b_q    <= srcb;
                if (!iter_op) begin
                    result      <= single_res;
                    zero        <= (single_res == '0);
                    div_by_zero <= 1'b0;
                    illegal_op  <= (op_in == ALU_ILLEGAL);
                    out_valid   <= 1'b1;
                end
            end else if (state_q == ITER) begin
                mul_acc_q  <= mul_acc_next;
                mul_a_q    <= mul_a_q << 1;
                mul_b_q    <= mul_b_q >> 1;
                iter_cnt_q <= iter_cnt_q + 1'b1;
                if (finish) begin
                    result      <= iter_res;
                    zero        <= (iter_res == '0);
                    div_by_zero <= is_div_op(op_q) && div_dbz;
                    illegal_op  <= 1'b0;
                    out_valid   <= 1'b1;
                    iter_cnt_q  <= '0;
                end
            end
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Execution stage that consumes the 4-bit alucontrol code from the ALU decoder, plus the two 19-bit operands from the register file/immediate mux.
- Logic, shift and add ops complete in 1 cycle.
- MUL, DIV and REM run iteratively, with a valid/ready handshake so control can stall the core while busy.
- Produces the result, zero flag and exception flags for writeback and branch logic.

Parameters:
- WIDTH, 19, datapath width in bits.
- SHAMT_W, 5, number of low bits of srcb used as the shift amount.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- alucontrol  in  4  op code (0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 INC, 0101 DEC, 0110 AND, 0111 OR, 1000 XOR, 1001 NOT, 1010 REM, 1011 SLT, 1100 SLL, 1101 SRL, 1110 SRA).
- srca  in  WIDTH  operand A.
- srcb  in  WIDTH  operand B / shift amount.
- out_valid  out  1  one-cycle result strobe.
- result  out  WIDTH  registered result; holds its value until the next out_valid.
- zero  out  1  result==0; valid with out_valid.
- div_by_zero  out  1  DIV/REM with srcb==0; valid with out_valid.
- illegal_op  out  1  alucontrol==1111; valid with out_valid.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (synchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, zero=0, div_by_zero=0, illegal_op=0, iteration counter=0.
- Accept: in_valid & in_ready at a rising edge; operands and op are captured there. A request while not ready is ignored, not queued.
- Single-cycle ops (everything except MUL/DIV/REM):
  - result is registered at the accept edge; out_valid is high for the following cycle.
  - Back-to-back issue is allowed every cycle.
- Iterative ops: FSM IDLE -> ITER -> IDLE.
  - ITER runs WIDTH iterations, one per edge.
  - The result is registered on the 19th ITER edge, and out_valid pulses the next cycle. Latency from accept edge to out_valid cycle is 20 cycles.
  - in_ready=0 and busy=1 throughout ITER.
  - in_ready returns to 1 in the out_valid cycle, so a new op may be accepted then.
- Arithmetic: all ops are modulo 2^WIDTH.
  - ADD/SUB/INC/DEC wrap.
  - MUL (shift-add, unsigned) returns the low WIDTH bits of the product.
  - DIV/REM are unsigned restoring division.
  - SLT is a signed compare; result is 1 or 0.
  - NOT returns ~srca.
- Shifts use srcb[SHAMT_W-1:0]. Shift amounts >= WIDTH give 0 for SLL/SRL and all-sign bits for SRA.
- Divide by zero:
  - DIV returns all ones (0x7FFFF); REM returns srca.
  - div_by_zero=1; still 20-cycle latency.
- Illegal op (1111): result=0, illegal_op=1, single-cycle.
- Flags deassert on any out_valid that does not set them.
- Reset mid-ITER: aborts immediately and returns to IDLE; the aborted op never produces out_valid.

Optional Feature:
- Macro ALU_FAST_MUL_EN.
- Defined: MUL is computed combinationally and treated as a single-cycle op (out_valid the cycle after accept; never enters ITER).
- Undefined: MUL uses the 20-cycle iterative path. DIV/REM are unaffected either way.

Decomposition:
- Package alu_pkg:
  - XLEN=19 and SHAMT_W=5 constants.
  - alu_op_e enum holding the 4-bit codes above, shared with the ALU decoder.
  - alu_state_e enum {IDLE, ITER}.
- Sub-module seq_divider:
  - Iterative restoring divider: start/done, dividend, divisor, quotient, remainder, dbz.
  - Instantiated once; MUL shift-add stays in the top block.

Test Plan:
- ADD 0x7FFFF + 0x00001 -> out_valid the cycle after accept; result=0x00000, zero=1. Then SUB issued on the next cycle, 5-7 -> result=0x7FFFE.
- MUL 300*500 -> in_ready=0 for 19 cycles; out_valid exactly 20 cycles after accept; result=150000 (0x249F0). With ALU_FAST_MUL_EN -> same result 1 cycle after accept.
- DIV 100000/7 -> result=14285. REM 100000/7 -> result=5. Both take 20 cycles, div_by_zero=0.
- DIV 1234/0 -> result=0x7FFFF, div_by_zero=1. REM 1234/0 -> result=1234, div_by_zero=1.
- Shift and compare:
  - SRA 0x40000 by 3 -> 0x78000.
  - SRL 0x40000 by 25 -> 0.
  - SLT 0x7FFFF vs 0x00001 -> 1.
  - alucontrol=1111 -> result=0, illegal_op=1.
- Reset asserted at the 10th ITER cycle of a DIV -> next cycle in_ready=1 and busy=0; no out_valid for the aborted op; a following ADD 2+3 returns 5.
